// File: rtl/vec_pkg.sv
// ----------------------------------------------------------------------------
// vec_pkg
// Shared definitions for the vector write-back path: width helpers, the bit
// positions of the functional-unit result word {valid, mask, data}, and the
// collector FSM state encoding.
// ----------------------------------------------------------------------------
package vec_pkg;

    // ceil(log2(v)); 0 for v <= 1
    function automatic int log2c(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Index width for a count of v items, never narrower than one bit
    function automatic int bitwidth(input int v);
        return (log2c(v) < 1) ? 1 : log2c(v);
    endfunction

    // Result word layout: [dw+1]=valid, [dw]=mask, [dw-1:0]=data
    function automatic int res_valid_pos(input int dw);
        return dw + 1;
    endfunction

    function automatic int res_mask_pos(input int dw);
        return dw;
    endfunction

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_e;

endpackage

// File: rtl/vec_wb_fifo.sv
// ----------------------------------------------------------------------------
// vec_wb_fifo
// Synchronous FIFO with registered storage and combinational head output.
// A push while full is only taken when a pop happens in the same cycle; a pop
// while empty is ignored. Pointers wrap naturally (DEPTH is a power of two).
// Ports:
//   clk, rst   clock, synchronous active-high reset (empties, zeroes storage)
//   push, din  write request and data
//   pop        remove head
//   dout       current head entry
//   count      occupancy, log2(DEPTH)+1 bits
//   full/empty occupancy flags
// ----------------------------------------------------------------------------
module vec_wb_fifo
    import vec_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PW   = log2c(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        mem_d   = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
        end
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/vec_wb_collector.sv
// ----------------------------------------------------------------------------
// vec_wb_collector
// Collects the per-element result stream of a vector functional unit, tags
// each element with its index, drops masked-off elements, buffers survivors
// and writes them to the destination vector register via an arbitrated port.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 begin one instruction (taken only when idle)
//   dest_reg, VLR         destination register / vector length, sampled on start
//   res_in                {valid, mask, data} from the functional unit
//   wr_req/wr_gnt         bank write handshake for the FIFO head
//   wr_reg/wr_idx/wr_data head write: register, element index, data
//   busy                  instruction in progress
//   done                  one-cycle completion pulse
//   overflow              sticky, a surviving element was lost to a full FIFO
// ----------------------------------------------------------------------------
module vec_wb_collector
    import vec_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MVL        = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int VREG_W     = 3,
    parameter int ID         = 0,
    localparam int IDX_W     = bitwidth(MVL)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [VREG_W-1:0]     dest_reg,
    input  logic [IDX_W:0]        VLR,
    input  logic [DATA_WIDTH+1:0] res_in,
    output logic                  wr_req,
    input  logic                  wr_gnt,
    output logic [VREG_W-1:0]     wr_reg,
    output logic [IDX_W-1:0]      wr_idx,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int CW = log2c(FIFO_DEPTH) + 1;
    localparam int FW = IDX_W + DATA_WIDTH;

    state_e              state_q, state_d;
    logic [IDX_W:0]      vlr_q, vlr_d;
    logic [VREG_W-1:0]   dreg_q, dreg_d;
    logic [IDX_W:0]      in_cnt_q, in_cnt_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;

    logic                res_valid, res_mask;
    logic                accept, push_req, push, pop;
    logic                fifo_full, fifo_empty;
    logic [CW-1:0]       fifo_count, count_nxt;
    logic [FW-1:0]       fifo_dout;

    assign res_valid = res_in[res_valid_pos(DATA_WIDTH)];
    assign res_mask  = res_in[res_mask_pos(DATA_WIDTH)];

    vec_wb_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({in_cnt_q[IDX_W-1:0], res_in[DATA_WIDTH-1:0]}),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        vlr_d    = vlr_q;
        dreg_d   = dreg_q;
        in_cnt_d = in_cnt_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;

        accept   = (state_q == ST_COLLECT) && res_valid && (in_cnt_q < vlr_q);
        push_req = accept && res_mask;
        pop      = !fifo_empty && wr_gnt;
        // A full FIFO can still take an element if the head leaves this cycle
        push     = push_req && (!fifo_full || pop);
        count_nxt = fifo_count + CW'(push) - CW'(pop);

        if (push_req && !push) begin
            ovf_d = 1'b1;
        end
        if (accept) begin
            in_cnt_d = in_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    vlr_d    = VLR;
                    dreg_d   = dest_reg;
                    in_cnt_d = '0;
                    state_d  = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                // Finish on the edge where the last element is counted and the
                // FIFO drains, so done lands in the cycle after the final grant
                if ((in_cnt_d == vlr_q) && (count_nxt == '0)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            vlr_q    <= '0;
            dreg_q   <= '0;
            in_cnt_q <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            vlr_q    <= vlr_d;
            dreg_q   <= dreg_d;
            in_cnt_q <= in_cnt_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    assign wr_req   = !fifo_empty;
    assign wr_reg   = dreg_q;
    assign wr_idx   = fifo_dout[FW-1:DATA_WIDTH];
    assign wr_data  = fifo_dout[DATA_WIDTH-1:0];
    assign busy     = (state_q == ST_COLLECT);
    assign done     = done_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_vec_wb_collector.sv
// ----------------------------------------------------------------------------
// tb_vec_wb_collector
// Table of instruction scenarios run through a cycle-level model; expected
// writes go into a queue and are compared as the DUT issues granted writes.
// Hand sequences cover reset mid-instruction.
// ----------------------------------------------------------------------------
module tb_vec_wb_collector;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    dest_reg;
    logic [5:0]    VLR;
    logic [DW+1:0] res_in;
    logic          wr_req;
    logic          wr_gnt;
    logic [2:0]    wr_reg;
    logic [4:0]    wr_idx;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic          overflow;

    vec_wb_collector #(
        .DATA_WIDTH (DW),
        .MVL        (32),
        .FIFO_DEPTH (DEPTH),
        .VREG_W     (3),
        .ID         (0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dest_reg (dest_reg),
        .VLR      (VLR),
        .res_in   (res_in),
        .wr_req   (wr_req),
        .wr_gnt   (wr_gnt),
        .wr_reg   (wr_reg),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          vlr;
        logic [2:0]  dreg;
        logic [31:0] mask;
        int          gnt_off;     // wr_gnt held low for this many cycles after start
        int          exp_writes;
        bit          exp_ovf;
    } vec_t;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    int         errs     = 0;
    int         checks   = 0;
    int         n_writes = 0;
    logic [2:0] cur_dest = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write monitor: every granted write must match the head of the scoreboard
    always @(negedge clk) begin
        wr_t e;
        if (!rst && wr_req && wr_gnt) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected_write: got idx=%0d data=%0h expected no write", wr_idx, wr_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_idx", 64'(wr_idx), 64'(e.idx));
                chk("wr_data", 64'(wr_data), 64'(e.data));
                chk("wr_reg", 64'(wr_reg), 64'(cur_dest));
            end
        end
    end

    task automatic do_reset();
        rst    = 1'b1;
        start  = 1'b0;
        wr_gnt = 1'b0;
        res_in = '0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("rst_wr_req", 64'(wr_req), 64'd0);
        chk("rst_wr_reg", 64'(wr_reg), 64'd0);
        chk("rst_wr_idx", 64'(wr_idx), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        // Results arriving while idle must not be buffered
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            res_in = {1'b1, 1'b1, 32'h0BAD_0000 + 32'(i)};
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        res_in = '0;
        @(negedge clk);
        chk("idle_no_push", 64'(wr_req), 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input int tno);
        int          cnt;
        bit          exp_done, finished, push, pop;
        logic [31:0] d;
        cur_dest = v.dreg;
        n_writes = 0;
        d        = '0;
        @(posedge clk);
        #1;
        start    = 1'b1;
        VLR      = 6'(v.vlr);
        dest_reg = v.dreg;
        res_in   = '0;
        wr_gnt   = 1'b0;
        @(posedge clk);
        #1;
        // Scramble the sampled inputs to show they were latched on start
        start    = 1'b0;
        VLR      = '1;
        dest_reg = ~v.dreg;
        cnt      = 0;
        exp_done = 1'b0;
        finished = 1'b0;
        for (int k = 1; k <= 80 && !finished; k++) begin
            push = 1'b0;
            if (k <= v.vlr) begin
                d      = 32'(tno * 1000 + 3 * k);
                push   = v.mask[k-1];
                res_in = {1'b1, v.mask[k-1], d};
            end else begin
                // Valid results beyond the vector length must be ignored
                res_in = {1'b1, 1'b1, 32'hDEAD_0000 + 32'(k)};
            end
            wr_gnt = (k > v.gnt_off);
            start  = (k == 2 && v.vlr >= 2);  // ignored while collecting
            @(negedge clk);
            chk("busy", 64'(busy), 64'(!exp_done));
            chk("done", 64'(done), 64'(exp_done));
            chk("wr_req", 64'(wr_req), 64'(cnt > 0));
            if (exp_done) begin
                finished = 1'b1;
            end else begin
                pop = wr_gnt && (cnt > 0);
                if (!(push && cnt == DEPTH && !pop)) begin
                    if (push) exp_q.push_back('{5'(k - 1), d});
                    cnt = cnt + int'(push) - int'(pop);
                end
                exp_done = (k >= v.vlr) && (cnt == 0);
                @(posedge clk);
                #1;
            end
        end
        if (!finished) begin
            checks++;
            errs++;
            $display("FAIL timeout_done: got no done expected done within 80 cycles (test %0d)", tno);
        end
        res_in = '0;
        start  = 1'b0;
        wr_gnt = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("writes", 64'(n_writes), 64'(v.exp_writes));
        chk("overflow", 64'(overflow), 64'(v.exp_ovf));
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    endtask

    vec_t tbl[7];
    vec_t v2;

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dest_reg = '0;
        VLR      = '0;
        res_in   = '0;
        wr_gnt   = 1'b0;

        tbl[0] = '{vlr: 4,  dreg: 3'd5, mask: 32'h0000_000F, gnt_off: 0, exp_writes: 4,  exp_ovf: 1'b0};
        tbl[1] = '{vlr: 4,  dreg: 3'd2, mask: 32'h0000_0005, gnt_off: 0, exp_writes: 2,  exp_ovf: 1'b0};
        tbl[2] = '{vlr: 8,  dreg: 3'd7, mask: 32'h0000_00FF, gnt_off: 8, exp_writes: 4,  exp_ovf: 1'b1};
        tbl[3] = '{vlr: 8,  dreg: 3'd1, mask: 32'h0000_00FF, gnt_off: 4, exp_writes: 8,  exp_ovf: 1'b0};
        tbl[4] = '{vlr: 0,  dreg: 3'd3, mask: 32'h0000_0000, gnt_off: 0, exp_writes: 0,  exp_ovf: 1'b0};
        tbl[5] = '{vlr: 8,  dreg: 3'd4, mask: 32'h0000_007F, gnt_off: 0, exp_writes: 7,  exp_ovf: 1'b0};
        tbl[6] = '{vlr: 32, dreg: 3'd6, mask: 32'hF0F0_3C3C, gnt_off: 3, exp_writes: 16, exp_ovf: 1'b0};

        for (int t = 0; t < 7; t++) begin
            do_reset();
            run_vec(tbl[t], t);
        end

        // Reset mid-instruction with two entries buffered
        do_reset();
        cur_dest = 3'd2;
        @(posedge clk);
        #1;
        start    = 1'b1;
        VLR      = 6'd4;
        dest_reg = 3'd2;
        @(posedge clk);
        #1;
        start  = 1'b0;
        wr_gnt = 1'b0;
        res_in = {1'b1, 1'b1, 32'd11};
        @(posedge clk);
        #1;
        res_in = {1'b1, 1'b1, 32'd22};
        @(posedge clk);
        #1;
        res_in = '0;
        @(negedge clk);
        chk("mid_wr_req", 64'(wr_req), 64'd1);
        chk("mid_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_wr_req", 64'(wr_req), 64'd0);
        chk("after_rst_busy", 64'(busy), 64'd0);
        chk("after_rst_done", 64'(done), 64'd0);
        v2 = '{vlr: 2, dreg: 3'd3, mask: 32'h0000_0003, gnt_off: 1, exp_writes: 2, exp_ovf: 1'b0};
        run_vec(v2, 9);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
